branch_hazard_ctrl: RTL and testbench
=====================================

BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on clk rising edge.
REQ-003 SHALL have inputs rs1_D, rs2_D, rd_D (5 each): decode-stage source and destination register indices.
REQ-004 SHALL have inputs reg_write_D, mem_read_D (1 each): decode instruction writes rd / is a load.
REQ-005 SHALL have inputs branch_D (3), jump_D (1), jump_type_D (1; 1=JAL, 0=JALR): decode control fields in branch/jump unit encoding; 010 and 011 = not a branch.
REQ-006 SHALL have input PC_src_D (1): redirect request from the decode-stage branch/jump unit.
REQ-007 SHALL have input hold (1): external pipeline freeze, e.g. memory busy.
REQ-008 SHALL have outputs forward_A_D, forward_B_D (2 each): 00 = none, 01 = from E, 10 = from M.
REQ-009 SHALL have outputs stall_F, stall_D, flush_D, flush_E (1 each), plus stall_cnt and flush_cnt (16 each): performance counters.

Function
REQ-010 SHALL hold a two-entry scoreboard, E and M; each entry = {valid, rd, reg_write, mem_read}.
REQ-011 Scoreboard advance per edge when hold=0: M<=E; E<=decode fields with valid=1, or a bubble (valid=0) when stall_D=1 or flush_D=1.
REQ-012 hold=1 SHALL freeze scoreboard and counters, and SHALL force stall_F=stall_D=1, flush_D=flush_E=0.
REQ-013 An entry "produces r" iff valid & reg_write & rd==r & r!=0; register x0 SHALL never cause forward or stall.
REQ-014 use_rs1 = (branch_D not 010/011) or (jump_D & jump_type_D==0); use_rs2 = (branch_D not 010/011) & ~jump_D.
REQ-015 Forward select, per used operand: E produces and ~E.mem_read -> 01; else M produces and ~M.mem_read -> 10; else 00. E SHALL take priority over M.
REQ-016 Load hazard: a used operand produced by E with mem_read, or by M with mem_read -> stall.
REQ-017 JALR hazard: the JALR target uses the unforwarded rs1, so jump_D & jump_type_D==0 with rs1 produced by E or M (any type) -> stall.
REQ-018 stall (hazard) SHALL drive stall_F=stall_D=flush_E=1 and forward_*=00; flush_D=0 while stalled.
REQ-019 flush_D = PC_src_D & ~stall & ~hold; PC_src_D SHALL be ignored while stalled.
REQ-020 Required stall lengths:
- load in E: 2 cycles;
- load in M: 1 cycle;
- JALR with ALU producer in E: 2 cycles, in M: 1 cycle.
REQ-021 forward/stall/flush outputs SHALL be combinational from scoreboard registers and D inputs, with zero-cycle latency.
REQ-022 stall_cnt +1 per non-hold cycle with hazard stall; flush_cnt +1 per cycle with flush_D; both saturate at 16'hFFFF.

Reset
REQ-023 rst_n=0 at an edge SHALL clear both scoreboard valid bits and both counters, overriding hold and all other inputs.
REQ-024 During and immediately after reset: forward_*=00, stall_F=stall_D=flush_E=0, flush_D=PC_src_D.
REQ-025 Reset asserted mid-stall SHALL end the stall on the next cycle.

Structure
REQ-026 Branch codes (BEQ..BGEU, BNT), JAL/JALR codes and forward codes (00/01/10) SHALL live in shared package core_pkg.
REQ-027 One sub-module hazard_sb_entry (registered entry with advance/bubble/hold controls) SHALL be instantiated twice, for E and M.

Verification
REQ-028 Producer ADD x5 in D, then BEQ x5,x6 next cycle -> forward_A_D=01, forward_B_D=00, no stall; one cycle later -> forward_A_D=10.
REQ-029 LW x7 then BNE x7,x0 -> stall_D=1 for exactly 2 cycles, flush_E=1 both cycles, then forward_A_D=00, stall_cnt=2.
REQ-030 ADDI x1 then JALR x1 -> 2 stall cycles; with one independent instruction between them -> 1 stall cycle.
REQ-031 Producer rd=x0 followed by BEQ x0,x0 -> no forward, no stall; PC_src_D=1 -> flush_D=1, flush_cnt=1.
REQ-032 hold=1 for 3 cycles mid load-stall -> scoreboard frozen, stall_cnt unchanged; after release, remaining stall cycles complete.
REQ-033 rst_n=0 for 1 cycle during a load stall -> next cycle stall_D=0, counters=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the decode-stage hazard logic: branch/jump codes,
// forward-select codes and the scoreboard entry layout.
package core_pkg;

  localparam int REG_W = 5;
  localparam int CNT_W = 16;

  localparam logic [2:0] BR_BEQ     = 3'b000;
  localparam logic [2:0] BR_BNE     = 3'b001;
  localparam logic [2:0] BR_BNT     = 3'b010;
  localparam logic [2:0] BR_BNT_ALT = 3'b011;
  localparam logic [2:0] BR_BLT     = 3'b100;
  localparam logic [2:0] BR_BGE     = 3'b101;
  localparam logic [2:0] BR_BLTU    = 3'b110;
  localparam logic [2:0] BR_BGEU    = 3'b111;

  localparam logic JT_JAL  = 1'b1;
  localparam logic JT_JALR = 1'b0;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_E    = 2'b01,
    FWD_M    = 2'b10
  } fwd_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } sb_entry_t;

  function automatic logic is_branch(input logic [2:0] br);
    logic res;
    res = 1'b0;
    unique case (br)
      BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU: res = 1'b1;
      BR_BNT, BR_BNT_ALT:                               res = 1'b0;
      default:                                          res = 1'b0;
    endcase
    return res;
  endfunction

  // x0 is hardwired zero, so it can never be a real producer.
  function automatic logic produces(input sb_entry_t e, input logic [REG_W-1:0] r);
    return e.valid & e.reg_write & (e.rd == r) & (r != '0);
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: captures the upstream entry each unfrozen edge,
// optionally replacing it with a bubble.
module hazard_sb_entry
  import core_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      hold,
  input  logic      bubble,
  input  sb_entry_t d,
  output sb_entry_t q
);

  logic             valid_q;
  logic [REG_W-1:0] rd_q;
  logic             reg_write_q;
  logic             mem_read_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (!hold) begin
      valid_q <= d.valid & ~bubble;
    end
  end

  // Payload carries no reset: it is meaningless while valid is low.
  always_ff @(posedge clk) begin
    if (!hold) begin
      rd_q        <= d.rd;
      reg_write_q <= d.reg_write;
      mem_read_q  <= d.mem_read;
    end
  end

  assign q = '{valid: valid_q, rd: rd_q, reg_write: reg_write_q, mem_read: mem_read_q};

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Decode-stage hazard unit: forwarding selects for branch/jump operands,
// load and JALR stalls, redirect flush, and stall/flush event counters.
module branch_hazard_ctrl
  import core_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs1_D,
  input  logic [REG_W-1:0] rs2_D,
  input  logic [REG_W-1:0] rd_D,
  input  logic             reg_write_D,
  input  logic             mem_read_D,
  input  logic [2:0]       branch_D,
  input  logic             jump_D,
  input  logic             jump_type_D,
  input  logic             PC_src_D,
  input  logic             hold,
  output logic [1:0]       forward_A_D,
  output logic [1:0]       forward_B_D,
  output logic             stall_F,
  output logic             stall_D,
  output logic             flush_D,
  output logic             flush_E,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  sb_entry_t        dec_entry;
  sb_entry_t        sb_e;
  sb_entry_t        sb_m;
  logic             use_rs1;
  logic             use_rs2;
  logic             is_jalr;
  logic             e_rs1;
  logic             m_rs1;
  logic             e_rs2;
  logic             m_rs2;
  logic             load_hz;
  logic             jalr_hz;
  logic             hazard;
  logic             bubble;
  fwd_t             fwd_a;
  fwd_t             fwd_b;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // E wins over M because it holds the younger value of the register.
  function automatic fwd_t pick_fwd(input logic used, input logic from_e, input logic e_load,
                                    input logic from_m, input logic m_load);
    fwd_t sel;
    sel = FWD_NONE;
    if (used && from_e && !e_load) begin
      sel = FWD_E;
    end else if (used && from_m && !m_load) begin
      sel = FWD_M;
    end
    return sel;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    dec_entry = '{valid: 1'b1, rd: rd_D, reg_write: reg_write_D, mem_read: mem_read_D};

    use_rs1 = is_branch(branch_D) | (jump_D & (jump_type_D != JT_JAL));
    use_rs2 = is_branch(branch_D) & ~jump_D;
    is_jalr = jump_D & (jump_type_D == JT_JALR);

    e_rs1 = produces(sb_e, rs1_D);
    m_rs1 = produces(sb_m, rs1_D);
    e_rs2 = produces(sb_e, rs2_D);
    m_rs2 = produces(sb_m, rs2_D);

    load_hz = (use_rs1 & ((e_rs1 & sb_e.mem_read) | (m_rs1 & sb_m.mem_read))) |
              (use_rs2 & ((e_rs2 & sb_e.mem_read) | (m_rs2 & sb_m.mem_read)));
    // The JALR target adder sits before the forwarding muxes.
    jalr_hz = is_jalr & (e_rs1 | m_rs1);
    hazard  = rst_n & (load_hz | jalr_hz);

    fwd_a = pick_fwd(use_rs1, e_rs1, sb_e.mem_read, m_rs1, sb_m.mem_read);
    fwd_b = pick_fwd(use_rs2, e_rs2, sb_e.mem_read, m_rs2, sb_m.mem_read);
  end

  always_comb begin
    forward_A_D = (hazard || !rst_n) ? FWD_NONE : fwd_a;
    forward_B_D = (hazard || !rst_n) ? FWD_NONE : fwd_b;
    stall_F     = rst_n & (hold | hazard);
    stall_D     = rst_n & (hold | hazard);
    flush_E     = hazard & ~hold;
    flush_D     = PC_src_D & ~hazard & (~hold | ~rst_n);
    bubble      = hazard | flush_D;
  end

  // ---- scoreboard: decode -> E -> M ----
  hazard_sb_entry u_sb_e (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (hold),
    .bubble (bubble),
    .d      (dec_entry),
    .q      (sb_e)
  );

  hazard_sb_entry u_sb_m (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (hold),
    .bubble (1'b0),
    .d      (sb_e),
    .q      (sb_m)
  );

  // ---- event counters ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!hold) begin
      if (hazard) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (flush_D) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Bench for branch_hazard_ctrl: directed vector table, multi-cycle corner
// sequences, and a randomized run against an instruction-history model.
module tb_branch_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_D, rs2_D, rd_D;
  logic        reg_write_D, mem_read_D;
  logic [2:0]  branch_D;
  logic        jump_D, jump_type_D, PC_src_D, hold;
  logic [1:0]  forward_A_D, forward_B_D;
  logic        stall_F, stall_D, flush_D, flush_E;
  logic [15:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  branch_hazard_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs1_D       (rs1_D),
    .rs2_D       (rs2_D),
    .rd_D        (rd_D),
    .reg_write_D (reg_write_D),
    .mem_read_D  (mem_read_D),
    .branch_D    (branch_D),
    .jump_D      (jump_D),
    .jump_type_D (jump_type_D),
    .PC_src_D    (PC_src_D),
    .hold        (hold),
    .forward_A_D (forward_A_D),
    .forward_B_D (forward_B_D),
    .stall_F     (stall_F),
    .stall_D     (stall_D),
    .flush_D     (flush_D),
    .flush_E     (flush_E),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       rw, mr;
    logic [2:0] br;
    logic       j, jt, pcs;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
  } slot_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pack(input logic [1:0] fa, input logic [1:0] fb, input logic sf,
                                      input logic sd, input logic fd, input logic fe);
    return {fa, fb, sf, sd, fd, fe};
  endfunction

  function automatic logic [7:0] outs();
    return {forward_A_D, forward_B_D, stall_F, stall_D, flush_D, flush_E};
  endfunction

  function automatic vec_t mk(input int r1, input int r2, input int d, input bit w, input bit m,
                              input logic [2:0] b, input bit jj, input bit t, input bit p,
                              input logic [7:0] e);
    vec_t v;
    v.rs1 = 5'(r1); v.rs2 = 5'(r2); v.rd = 5'(d);
    v.rw = w; v.mr = m; v.br = b; v.j = jj; v.jt = t; v.pcs = p; v.exp = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r1, input int r2, input int d, input bit w, input bit m,
                       input logic [2:0] b, input bit jj, input bit t, input bit p);
    rs1_D = 5'(r1); rs2_D = 5'(r2); rd_D = 5'(d);
    reg_write_D = w; mem_read_D = m; branch_D = b;
    jump_D = jj; jump_type_D = t; PC_src_D = p;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 3'b010, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hold  = 1'b0;
    nop();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic count_stalls(input int limit, output int n);
    n = 0;
    for (int i = 0; i < limit; i++) begin
      #3;
      if (stall_D) begin
        n++;
        tick();
      end else begin
        break;
      end
    end
  endtask

  function automatic bit makes(input slot_t s, input int r);
    return s.v && s.wr && (s.rd == r) && (r != 0);
  endfunction

  initial begin
    int n;
    slot_t pe, pm;
    int scnt, fcnt;
    bit uses1, uses2, ld_hit, stl, fdx;
    int fa, fb;
    logic [7:0] expo;

    // Reset state, with hold asserted to show reset wins.
    rst_n = 1'b0;
    hold  = 1'b1;
    drive(0, 0, 0, 0, 0, 3'b010, 0, 0, 1);
    tick();
    #3;
    check("reset_outs", outs(), pack(0, 0, 0, 0, 1, 0));
    check("reset_stall_cnt", stall_cnt, 0);
    check("reset_flush_cnt", flush_cnt, 0);
    hold = 1'b0;
    tick();
    rst_n = 1'b1;
    #3;
    check("post_reset_outs", outs(), pack(0, 0, 0, 0, 1, 0));

    // Directed vectors, applied back-to-back from a clean scoreboard.
    vecs.push_back(mk(1, 2, 5, 1, 0, 3'b010, 0, 0, 0, pack(0, 0, 0, 0, 0, 0)));  // ADD x5
    vecs.push_back(mk(5, 6, 0, 0, 0, 3'b000, 0, 0, 0, pack(1, 0, 0, 0, 0, 0)));  // BEQ x5,x6
    vecs.push_back(mk(5, 6, 0, 0, 0, 3'b000, 0, 0, 0, pack(2, 0, 0, 0, 0, 0)));  // BEQ x5,x6
    vecs.push_back(mk(0, 0, 5, 1, 0, 3'b010, 0, 0, 0, pack(0, 0, 0, 0, 0, 0)));  // ADD x5
    vecs.push_back(mk(0, 0, 6, 1, 0, 3'b010, 0, 0, 0, pack(0, 0, 0, 0, 0, 0)));  // ADD x6
    vecs.push_back(mk(5, 6, 0, 0, 0, 3'b001, 0, 0, 0, pack(2, 1, 0, 0, 0, 0)));  // BNE x5,x6
    vecs.push_back(mk(0, 0, 9, 1, 0, 3'b010, 0, 0, 0, pack(0, 0, 0, 0, 0, 0)));  // ADD x9
    vecs.push_back(mk(0, 0, 9, 1, 0, 3'b010, 0, 0, 0, pack(0, 0, 0, 0, 0, 0)));  // ADD x9
    vecs.push_back(mk(9, 9, 0, 0, 0, 3'b100, 0, 0, 0, pack(1, 1, 0, 0, 0, 0)));  // BLT x9,x9
    vecs.push_back(mk(9, 9, 1, 1, 0, 3'b010, 1, 1, 1, pack(0, 0, 0, 0, 1, 0)));  // JAL, taken
    vecs.push_back(mk(0, 0, 0, 1, 0, 3'b010, 0, 0, 0, pack(0, 0, 0, 0, 0, 0)));  // ADD x0
    vecs.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 1, pack(0, 0, 0, 0, 1, 0)));  // BEQ x0,x0 taken
    vecs.push_back(mk(9, 9, 1, 1, 0, 3'b010, 1, 0, 0, pack(0, 0, 0, 0, 0, 0)));  // JALR x9
    vecs.push_back(mk(1, 0, 0, 0, 0, 3'b111, 0, 0, 0, pack(1, 0, 0, 0, 0, 0)));  // BGEU x1,x0
    vecs.push_back(mk(1, 1, 0, 0, 0, 3'b011, 0, 0, 0, pack(0, 0, 0, 0, 0, 0)));  // code 011
    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].br,
            vecs[i].j, vecs[i].jt, vecs[i].pcs);
      #3;
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      tick();
    end
    nop();
    #3;
    check("vec_flush_cnt", flush_cnt, 2);

    // LW x7 then BNE x7,x0 with a redirect request that must wait.
    do_reset();
    drive(0, 0, 7, 1, 1, 3'b010, 0, 0, 0);
    tick();
    drive(7, 0, 0, 0, 0, 3'b001, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      #3;
      check($sformatf("lw_stall%0d", k), outs(), pack(0, 0, 1, 1, 0, 1));
      tick();
    end
    #3;
    check("lw_release", outs(), pack(0, 0, 0, 0, 1, 0));
    check("lw_stall_cnt", stall_cnt, 2);
    tick();
    nop();
    #3;
    check("lw_flush_cnt", flush_cnt, 1);

    // ADDI x1 then JALR x1: two stalls.
    do_reset();
    drive(0, 0, 1, 1, 0, 3'b010, 0, 0, 0);
    tick();
    drive(1, 0, 2, 1, 0, 3'b010, 1, 0, 0);
    count_stalls(6, n);
    check("jalr_e_stalls", n, 2);

    // ADDI x1, independent ADD x3, JALR x1: one stall.
    do_reset();
    drive(0, 0, 1, 1, 0, 3'b010, 0, 0, 0);
    tick();
    drive(2, 0, 3, 1, 0, 3'b010, 0, 0, 0);
    tick();
    drive(1, 0, 2, 1, 0, 3'b010, 1, 0, 0);
    count_stalls(6, n);
    check("jalr_m_stalls", n, 1);

    // Load already in M: one stall.
    do_reset();
    drive(0, 0, 7, 1, 1, 3'b010, 0, 0, 0);
    tick();
    nop();
    tick();
    drive(0, 7, 0, 0, 0, 3'b000, 0, 0, 0);
    count_stalls(6, n);
    check("lw_m_stalls", n, 1);

    // Hold for three cycles in the middle of a load stall.
    do_reset();
    drive(0, 0, 7, 1, 1, 3'b010, 0, 0, 0);
    tick();
    drive(7, 0, 0, 0, 0, 3'b001, 0, 0, 1);
    #3;
    check("hold_pre_stall", outs(), pack(0, 0, 1, 1, 0, 1));
    tick();
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #3;
      check($sformatf("hold_outs%0d", k), outs(), pack(0, 0, 1, 1, 0, 0));
      check($sformatf("hold_stall_cnt%0d", k), stall_cnt, 1);
      tick();
    end
    hold = 1'b0;
    count_stalls(6, n);
    check("hold_rest_stalls", n, 1);
    check("hold_stall_cnt_end", stall_cnt, 2);
    check("hold_release_outs", outs(), pack(0, 0, 0, 0, 1, 0));

    // Reset pulse during a load stall.
    do_reset();
    drive(0, 0, 7, 1, 1, 3'b010, 0, 0, 0);
    tick();
    drive(7, 0, 0, 0, 0, 3'b001, 0, 0, 1);
    #3;
    check("rst_pre_stall", stall_D, 1);
    tick();
    rst_n = 1'b0;
    #3;
    check("rst_during", outs(), pack(0, 0, 0, 0, 1, 0));
    tick();
    rst_n = 1'b1;
    #3;
    check("rst_after", outs(), pack(0, 0, 0, 0, 1, 0));
    check("rst_after_stall_cnt", stall_cnt, 0);
    check("rst_after_flush_cnt", flush_cnt, 0);
    tick();

    // Randomized run against an instruction-history model.
    do_reset();
    pe = '{v: 0, rd: 0, wr: 0, ld: 0};
    pm = pe;
    scnt = 0;
    fcnt = 0;
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            1'($urandom), 1'($urandom), 3'($urandom), ($urandom % 3) == 0,
            1'($urandom), ($urandom % 4) == 0);
      hold  = ($urandom % 8) == 0;
      rst_n = ($urandom % 40) != 0;
      #3;

      uses1 = !(branch_D == 3'd2 || branch_D == 3'd3) || (jump_D && !jump_type_D);
      uses2 = !(branch_D == 3'd2 || branch_D == 3'd3) && !jump_D;
      ld_hit = (uses1 && ((makes(pe, rs1_D) && pe.ld) || (makes(pm, rs1_D) && pm.ld))) ||
               (uses2 && ((makes(pe, rs2_D) && pe.ld) || (makes(pm, rs2_D) && pm.ld)));
      stl = rst_n && (ld_hit ||
            (jump_D && !jump_type_D && (makes(pe, rs1_D) || makes(pm, rs1_D))));
      fa = 0;
      if (uses1 && makes(pe, rs1_D) && !pe.ld) fa = 1;
      else if (uses1 && makes(pm, rs1_D) && !pm.ld) fa = 2;
      fb = 0;
      if (uses2 && makes(pe, rs2_D) && !pe.ld) fb = 1;
      else if (uses2 && makes(pm, rs2_D) && !pm.ld) fb = 2;

      if (!rst_n) begin
        fdx  = PC_src_D;
        expo = pack(0, 0, 0, 0, fdx, 0);
      end else begin
        fdx  = PC_src_D && !stl && !hold;
        expo = pack(stl ? 2'd0 : 2'(fa), stl ? 2'd0 : 2'(fb), hold || stl, hold || stl,
                    fdx, stl && !hold);
      end
      check($sformatf("rnd%0d_outs", c), outs(), expo);
      check($sformatf("rnd%0d_stall_cnt", c), stall_cnt, scnt);
      check($sformatf("rnd%0d_flush_cnt", c), flush_cnt, fcnt);

      if (!rst_n) begin
        pe.v = 0;
        pm.v = 0;
        scnt = 0;
        fcnt = 0;
      end else if (!hold) begin
        if (stl && scnt < 65535) scnt++;
        if (fdx && fcnt < 65535) fcnt++;
        pm = pe;
        pe = '{v: !(stl || fdx), rd: int'(rd_D), wr: reg_write_D, ld: mem_read_D};
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
